mapper_banked: RTL

MAPPER_BANKED -- requirements
Module: mapper_banked

---
 rtl/mapper_banked_pkg.sv | 49 ++++
 rtl/mapper_banked.sv | 105 ++++++++++
 2 files changed

// File: rtl/mapper_banked_pkg.sv
// Shared slot definitions: mapper/device type enums, bus structs, and the
// bank-register FSM state type. Imported by mapper_banked.
package mapper_banked_pkg;

  typedef enum logic [2:0] {
    MAP_NONE      = 3'd0,
    MAPPER_ROM    = 3'd1,
    MAPPER_BANKED = 3'd2,
    MAPPER_RAM    = 3'd3
  } mapper_t;

  typedef enum logic [1:0] {
    DEV_NONE = 2'd0,
    DEV_SCC  = 2'd1,
    DEV_OPL  = 2'd2
  } device_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        mreq;
    logic        wr;
    logic        rd;
  } cpu_bus_t;

  typedef struct packed {
    mapper_t     typ;
    logic [12:0] offset_ram;   // 16 KB units
    logic [13:0] offset_sram;  // 8 KB units
    device_t     device;
  } block_info_t;

  typedef struct packed {
    logic        ram_cs;
    logic        sram_cs;
    logic [26:0] addr;
    logic        rnw;
  } out_t;

  typedef struct packed {
    device_t typ;
  } device_out_t;

endpackage

// File: rtl/mapper_banked.sv
// Banked ROM mapper (ASCII8/ASCII16 style) covering 0x4000-0xBFFF.
// Optional battery SRAM banking is enabled with MAPPER_BANKED_SRAM_EN.
module mapper_banked
  import mapper_banked_pkg::*;
#(
  parameter int unsigned BANK_BITS = 13,
  parameter int unsigned REG_BITS  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  cpu_bus_t    cpu_bus,
  input  block_info_t block_info,
  output out_t        out,
  output device_out_t device_out
);

  localparam int unsigned IDX_W      = 15 - BANK_BITS;
  localparam int unsigned BANK_COUNT = 1 << IDX_W;

  logic [REG_BITS-1:0] bank_q [BANK_COUNT];
  state_t              state_q;
  logic                armed_q;

  logic                is_banked;
  logic                sel;
  logic                reg_hit;
  logic                txn_end;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic [REG_BITS-1:0] cur_bank;
  logic [26:0]         rom_addr;
  logic                unused_bits;

  assign is_banked = (block_info.typ == MAPPER_BANKED);
  assign sel       = is_banked & cpu_bus.mreq &
                     ((cpu_bus.addr[15:14] == 2'b01) | (cpu_bus.addr[15:14] == 2'b10));
  assign reg_hit   = sel & cpu_bus.wr & (cpu_bus.addr[15:13] == 3'b011);
  assign txn_end   = ~cpu_bus.wr | ~cpu_bus.mreq | ~is_banked;
  assign rd_idx    = IDX_W'((cpu_bus.addr - 16'h4000) >> BANK_BITS);
  assign wr_idx    = cpu_bus.addr[12 -: IDX_W];
  assign cur_bank  = bank_q[rd_idx];
  assign rom_addr  = {block_info.offset_ram, 14'b0}
                   + (27'(cur_bank) << BANK_BITS)
                   + 27'(cpu_bus.addr[BANK_BITS-1:0]);

  assign unused_bits = ^{cpu_bus.rd, block_info.offset_sram};

  // Bank register file and one-update-per-write FSM.
  // armed_q stays low from reset until the bus is seen idle, so a write still
  // held across reset release parks in HOLD without being re-applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BANK_COUNT; i++) begin
        bank_q[i] <= '0;
      end
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
    end else begin
      if (txn_end) begin
        armed_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (reg_hit) begin
            if (armed_q) begin
              bank_q[wr_idx] <= cpu_bus.data[REG_BITS-1:0];
            end
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (txn_end) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Address translation and chip selects.
  always_comb begin
    out.ram_cs  = 1'b0;
    out.sram_cs = 1'b0;
    out.addr    = '1;
    out.rnw     = 1'b1;
`ifdef MAPPER_BANKED_SRAM_EN
    if (sel & cpu_bus.addr[15] & cur_bank[REG_BITS-1]) begin
      out.sram_cs = 1'b1;
      out.addr    = {block_info.offset_sram, cpu_bus.addr[12:0]};
      out.rnw     = ~cpu_bus.wr;
    end else
`endif
    if (sel & ~cpu_bus.wr) begin
      out.ram_cs = 1'b1;
      out.addr   = rom_addr;
    end
  end

  // Device type passthrough while this slot is selected.
  always_comb begin
    device_out.typ = sel ? block_info.device : DEV_NONE;
  end

endmodule
